// File: rtl/dds_phase_accum.sv
// Phase accumulator feeding the sine ROM. Tuning words arrive as framed bytes
// from the UART receiver and are committed atomically once the frame completes.
module dds_phase_accum #(
   parameter int               ACC_W       = 24,
   parameter int               ADDR_W      = 10,
   parameter logic [ACC_W-1:0] FTW_DEFAULT = 24'h004000,
   parameter int               TIMEOUT_CYC = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              enable,
   output logic [ADDR_W-1:0] address,
   output logic [ACC_W-1:0]  ftw,
   output logic              ftw_update,
   output logic              frame_busy
);

   localparam int NBYTES = ACC_W / 8;
   localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

   localparam logic [7:0] CMD_LOAD  = 8'hA5;
   localparam logic [7:0] CMD_PHASE = 8'h5A;

   typedef enum logic {
      IDLE,
      LOAD
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] byte_cnt;
   logic [CNT_W-1:0] byte_cnt_next;
   logic [TMO_W-1:0] tmo_cnt;
   logic [TMO_W-1:0] tmo_next;
   logic [ACC_W-1:0] shadow;
   logic [ACC_W-1:0] shadow_next;
   logic [ACC_W-1:0] acc;
   logic             commit;
   logic             phase_clr;

   // Frame decoder: command bytes only mean something in IDLE, payload bytes are raw data.
   always_comb begin
      state_next    = state;
      byte_cnt_next = byte_cnt;
      tmo_next      = tmo_cnt;
      shadow_next   = shadow;
      commit        = 1'b0;
      phase_clr     = 1'b0;

      case (state)
         IDLE: begin
            tmo_next = '0;
            if (rx_valid) begin
               if (rx_data == CMD_LOAD) begin
                  state_next    = LOAD;
                  byte_cnt_next = '0;
               end else if (rx_data == CMD_PHASE) begin
                  phase_clr = 1'b1;
               end
            end
         end

         LOAD: begin
            if (rx_valid) begin
               shadow_next = {shadow[ACC_W-9:0], rx_data};
               tmo_next    = '0;
               if (byte_cnt == LAST_BYTE) begin
                  commit        = 1'b1;
                  state_next    = IDLE;
                  byte_cnt_next = '0;
               end else begin
                  byte_cnt_next = byte_cnt + CNT_W'(1);
               end
            end else if (tmo_cnt == TMO_LAST) begin
               // A byte in the expiry cycle is handled above, so it wins over the timeout.
               state_next    = IDLE;
               byte_cnt_next = '0;
               tmo_next      = '0;
               shadow_next   = '0;
            end else begin
               tmo_next = tmo_cnt + TMO_W'(1);
            end
         end

         default: begin
            state_next    = IDLE;
            byte_cnt_next = '0;
            tmo_next      = '0;
         end
      endcase
   end

   // The accumulator reads the old ftw at the commit edge; the new word takes effect one edge later.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         byte_cnt   <= '0;
         tmo_cnt    <= '0;
         shadow     <= '0;
         acc        <= '0;
         ftw        <= FTW_DEFAULT;
         ftw_update <= 1'b0;
      end else begin
         state      <= state_next;
         byte_cnt   <= byte_cnt_next;
         tmo_cnt    <= tmo_next;
         shadow     <= shadow_next;
         ftw_update <= commit;
         if (commit) begin
            ftw <= shadow_next;
         end
         if (phase_clr) begin
            acc <= '0;
         end else if (enable) begin
            acc <= acc + ftw;
         end
      end
   end

   assign address    = acc[ACC_W-1 -: ADDR_W];
   assign frame_busy = (state == LOAD);

endmodule
